// File: rtl/ct_ifu_bht_pkg.sv
// Shared definitions for the IFU BHT write-side controller: FSM encoding,
// counter saturation limits, array geometry and the queued update record.
package ct_ifu_bht_pkg;

    // BHT geometry: 1024 entries, 16 two-bit counters per entry.
    localparam int BHT_IDX_W  = 10;
    localparam int BHT_SLOTS  = 16;
    localparam int BHT_CNT_W  = 2;
    localparam int BHT_LINE_W = BHT_SLOTS * BHT_CNT_W;

    // Counter limits and the value written by the full-array invalidate.
    localparam logic [BHT_CNT_W-1:0] SAT_MAX     = 2'd3;
    localparam logic [BHT_CNT_W-1:0] SAT_MIN     = 2'd0;
    localparam logic [BHT_CNT_W-1:0] BHT_INV_VAL = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INV  = 2'd1,
        ST_DONE = 2'd2
    } bht_wr_state_e;

    // One pending array write; the counter is already saturated.
    typedef struct packed {
        logic [BHT_IDX_W-1:0] idx;
        logic [3:0]           offset;
        logic                 sel;
        logic [BHT_CNT_W-1:0] cnt_new;
    } bht_upd_entry_t;

    // Two-bit saturating counter step toward the resolved direction.
    function automatic logic [BHT_CNT_W-1:0] sat_next(input logic [BHT_CNT_W-1:0] cnt,
                                                       input logic taken);
        if (taken) begin
            return (cnt == SAT_MAX) ? SAT_MAX : cnt + 2'd1;
        end
        return (cnt == SAT_MIN) ? SAT_MIN : cnt - 2'd1;
    endfunction

    // Bit write enable covering only the addressed counter slot.
    function automatic logic [BHT_LINE_W-1:0] slot_bwen(input logic [3:0] offset);
        logic [BHT_LINE_W-1:0] m;
        m = 32'h3 << {offset, 1'b0};
        return m;
    endfunction

endpackage

// File: rtl/ct_ifu_bht_wr_ctrl_if.sv
// Bundle of the IU update, cp0/ifctrl control and BHT array write signals.
// Handshake: an update is offered when iu_bht_upd_vld is high for one cycle;
// there is no back-pressure, overflow is reported through bht_upd_drop, and
// bht_rd_busy stalls array writes (not updates) for as long as it is high.
interface ct_ifu_bht_wr_ctrl_if
    import ct_ifu_bht_pkg::*;
#(
    parameter int IDX_WIDTH = BHT_IDX_W
);
    logic                  cp0_ifu_bht_en;
    logic                  ifctrl_bht_inv;
    logic                  bht_rd_busy;
    logic                  iu_bht_upd_vld;
    logic [IDX_WIDTH-1:0]  iu_bht_upd_idx;
    logic [3:0]            iu_bht_upd_offset;
    logic                  iu_bht_upd_sel;
    logic [BHT_CNT_W-1:0]  iu_bht_upd_cnt;
    logic                  iu_bht_upd_taken;

    logic                  bht_wr_vld;
    logic [IDX_WIDTH-1:0]  bht_wr_idx;
    logic                  bht_wr_sel_taken;
    logic                  bht_wr_sel_ntake;
    logic [BHT_LINE_W-1:0] bht_wr_bwen;
    logic [BHT_LINE_W-1:0] bht_wr_data;
    logic                  bht_upd_drop;
    logic                  bht_ifctrl_inv_on;
    logic                  bht_ifctrl_inv_done;
    bht_wr_state_e         dbg_state;

    modport master (
        output cp0_ifu_bht_en, ifctrl_bht_inv, bht_rd_busy,
        output iu_bht_upd_vld, iu_bht_upd_idx, iu_bht_upd_offset,
        output iu_bht_upd_sel, iu_bht_upd_cnt, iu_bht_upd_taken,
        input  bht_wr_vld, bht_wr_idx, bht_wr_sel_taken, bht_wr_sel_ntake,
        input  bht_wr_bwen, bht_wr_data, bht_upd_drop,
        input  bht_ifctrl_inv_on, bht_ifctrl_inv_done, dbg_state
    );

    modport slave (
        input  cp0_ifu_bht_en, ifctrl_bht_inv, bht_rd_busy,
        input  iu_bht_upd_vld, iu_bht_upd_idx, iu_bht_upd_offset,
        input  iu_bht_upd_sel, iu_bht_upd_cnt, iu_bht_upd_taken,
        output bht_wr_vld, bht_wr_idx, bht_wr_sel_taken, bht_wr_sel_ntake,
        output bht_wr_bwen, bht_wr_data, bht_upd_drop,
        output bht_ifctrl_inv_on, bht_ifctrl_inv_done, dbg_state
    );
endinterface

// File: rtl/ct_ifu_bht_upd_fifo.sv
// Small FIFO holding pending BHT updates. Push and pop may coincide when full;
// clear wins over push/pop in the same cycle.
module ct_ifu_bht_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 17
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;

    // Pointer and occupancy tracking; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_i && !pop_i)      cnt_q <= cnt_q + 1'b1;
            else if (pop_i && !push_i) cnt_q <= cnt_q - 1'b1;
        end
    end

    // Storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/ct_ifu_bht_wr_ctrl.sv
// BHT write controller: saturates resolved branch counters, queues them and
// writes the arrays when the read path is idle; also walks the whole array
// on an invalidate request.
module ct_ifu_bht_wr_ctrl
    import ct_ifu_bht_pkg::*;
#(
    parameter int                   IDX_WIDTH = BHT_IDX_W,
    parameter int                   QDEPTH    = 4,
    parameter logic [BHT_CNT_W-1:0] INV_VAL   = BHT_INV_VAL
) (
    input logic                 forever_cpuclk,
    input logic                 cpurst_b,
    ct_ifu_bht_wr_ctrl_if.slave bif
);
    bht_wr_state_e         state_q;
    logic [IDX_WIDTH-1:0]  walk_q;
    logic                  armed_q;
    logic                  wr_vld_q, wr_sel_t_q, wr_sel_n_q;
    logic [IDX_WIDTH-1:0]  wr_idx_q;
    logic [BHT_LINE_W-1:0] wr_bwen_q, wr_data_q;
    logic                  drop_q, inv_on_q, inv_done_q;

    bht_upd_entry_t in_ent, q_ent, wr_ent;
    logic idle, go_inv, can_wr, push_req, q_clr, q_push, q_pop, bypass, wr_go, drop_d;
    logic q_full, q_empty;

    // Update path: saturate, decide bypass/enqueue/drop, pick the write source.
    always_comb begin
        in_ent.idx     = BHT_IDX_W'(bif.iu_bht_upd_idx);
        in_ent.offset  = bif.iu_bht_upd_offset;
        in_ent.sel     = bif.iu_bht_upd_sel;
        in_ent.cnt_new = sat_next(bif.iu_bht_upd_cnt, bif.iu_bht_upd_taken);
        idle     = (state_q == ST_IDLE);
        go_inv   = idle && bif.ifctrl_bht_inv && armed_q;
        q_clr    = !bif.cp0_ifu_bht_en || go_inv;
        can_wr   = idle && bif.cp0_ifu_bht_en && !bif.bht_rd_busy && !go_inv;
        // A saturated counter needs no write, so it never occupies the queue.
        push_req = bif.iu_bht_upd_vld && bif.cp0_ifu_bht_en && idle && !go_inv
                   && (in_ent.cnt_new != bif.iu_bht_upd_cnt);
        q_pop    = can_wr && !q_empty;
        // Empty queue and a free array: write straight through for 1-cycle latency.
        bypass   = can_wr && q_empty && push_req;
        q_push   = push_req && !bypass && (!q_full || q_pop);
        drop_d   = push_req && q_full && !q_pop;
        wr_go    = q_pop || bypass;
        wr_ent   = q_pop ? q_ent : in_ent;
    end

    ct_ifu_bht_upd_fifo #(
        .DEPTH (QDEPTH),
        .DW    ($bits(bht_upd_entry_t))
    ) u_fifo (
        .clk_i   (forever_cpuclk),
        .rst_n_i (cpurst_b),
        .clr_i   (q_clr),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .wdata_i (in_ent),
        .rdata_o (q_ent),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    // Invalidate FSM and all registered array-write / status outputs.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q    <= ST_IDLE;
            walk_q     <= '0;
            armed_q    <= 1'b1;
            wr_vld_q   <= 1'b0;
            wr_idx_q   <= '0;
            wr_sel_t_q <= 1'b0;
            wr_sel_n_q <= 1'b0;
            wr_bwen_q  <= '0;
            wr_data_q  <= '0;
            drop_q     <= 1'b0;
            inv_on_q   <= 1'b0;
            inv_done_q <= 1'b0;
        end else begin
            wr_vld_q   <= 1'b0;
            inv_done_q <= 1'b0;
            drop_q     <= drop_d;
            case (state_q)
                ST_IDLE: begin
                    // A held-high request re-arms only after being seen low here.
                    armed_q <= !bif.ifctrl_bht_inv;
                    if (go_inv) begin
                        // Entry 0 is written on the way in, so the walk resumes at 1.
                        state_q    <= ST_INV;
                        inv_on_q   <= 1'b1;
                        walk_q     <= IDX_WIDTH'(1);
                        wr_vld_q   <= 1'b1;
                        wr_idx_q   <= '0;
                        wr_sel_t_q <= 1'b1;
                        wr_sel_n_q <= 1'b1;
                        wr_bwen_q  <= '1;
                        wr_data_q  <= {BHT_SLOTS{INV_VAL}};
                    end else if (wr_go) begin
                        wr_vld_q   <= 1'b1;
                        wr_idx_q   <= IDX_WIDTH'(wr_ent.idx);
                        wr_sel_t_q <= wr_ent.sel;
                        wr_sel_n_q <= !wr_ent.sel;
                        wr_bwen_q  <= slot_bwen(wr_ent.offset);
                        wr_data_q  <= {BHT_SLOTS{wr_ent.cnt_new}};
                    end
                end
                ST_INV: begin
                    // Read path is blocked by ifctrl while inv_on, so no rd_busy hold.
                    wr_vld_q   <= 1'b1;
                    wr_idx_q   <= walk_q;
                    wr_sel_t_q <= 1'b1;
                    wr_sel_n_q <= 1'b1;
                    wr_bwen_q  <= '1;
                    wr_data_q  <= {BHT_SLOTS{INV_VAL}};
                    if (walk_q == {IDX_WIDTH{1'b1}}) state_q <= ST_DONE;
                    else                             walk_q  <= walk_q + 1'b1;
                end
                ST_DONE: begin
                    inv_on_q   <= 1'b0;
                    inv_done_q <= 1'b1;
                    walk_q     <= '0;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bif.bht_wr_vld          = wr_vld_q;
    assign bif.bht_wr_idx          = wr_idx_q;
    assign bif.bht_wr_sel_taken    = wr_sel_t_q;
    assign bif.bht_wr_sel_ntake    = wr_sel_n_q;
    assign bif.bht_wr_bwen         = wr_bwen_q;
    assign bif.bht_wr_data         = wr_data_q;
    assign bif.bht_upd_drop        = drop_q;
    assign bif.bht_ifctrl_inv_on   = inv_on_q;
    assign bif.bht_ifctrl_inv_done = inv_done_q;
    assign bif.dbg_state           = state_q;
endmodule

// File: tb/tb_ct_ifu_bht_wr_ctrl.sv
// Directed bench for the BHT write controller: a vector table for single
// updates plus hand sequences for queueing, invalidate, disable and reset.
module tb_ct_ifu_bht_wr_ctrl;
    import ct_ifu_bht_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [9:0] exp_q[$];

    ct_ifu_bht_wr_ctrl_if #(.IDX_WIDTH(10)) bif ();

    ct_ifu_bht_wr_ctrl #(.IDX_WIDTH(10), .QDEPTH(4), .INV_VAL(2'b01)) dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_n),
        .bif            (bif)
    );

    // Clock
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [9:0]  idx;
        logic [3:0]  off;
        logic        sel;
        logic [1:0]  cnt;
        logic        tk;
        logic        e_vld;
        logic [31:0] e_bwen;
        logic [31:0] e_data;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic v, input logic [9:0] idx, input logic [3:0] off,
                           input logic sel, input logic [1:0] cnt, input logic tk);
        bif.iu_bht_upd_vld    = v;
        bif.iu_bht_upd_idx    = idx;
        bif.iu_bht_upd_offset = off;
        bif.iu_bht_upd_sel    = sel;
        bif.iu_bht_upd_cnt    = cnt;
        bif.iu_bht_upd_taken  = tk;
    endtask

    task automatic chk_idle(input string name);
        chk(name, {bif.bht_wr_vld, bif.bht_upd_drop}, 2'b00);
    endtask

    task automatic chk_wr(input string name, input logic [9:0] idx, input logic sel,
                          input logic [31:0] bwen, input logic [31:0] data);
        chk(name, {bif.bht_wr_vld, bif.bht_wr_idx, bif.bht_wr_sel_taken, bif.bht_wr_sel_ntake,
                   bif.bht_wr_bwen, bif.bht_wr_data, bif.bht_upd_drop},
                  {1'b1, idx, sel, !sel, bwen, data, 1'b0});
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {bif.bht_wr_vld, bif.bht_wr_idx, bif.bht_wr_sel_taken, bif.bht_wr_sel_ntake,
                   bif.bht_wr_bwen, bif.bht_wr_data, bif.bht_upd_drop,
                   bif.bht_ifctrl_inv_on, bif.bht_ifctrl_inv_done}, '0);
    endtask

    // Checks the 1024 invalidate writes; the first one must be visible on entry.
    task automatic run_walk(input string name);
        for (int k = 0; k < 1024; k++) begin
            chk(name, {bif.bht_wr_vld, bif.bht_wr_sel_taken, bif.bht_wr_sel_ntake, bif.bht_wr_idx,
                       bif.bht_wr_bwen, bif.bht_wr_data, bif.bht_ifctrl_inv_on,
                       bif.bht_ifctrl_inv_done, bif.bht_upd_drop},
                      {3'b111, 10'(k), 32'hFFFF_FFFF, 32'h5555_5555, 3'b100});
            if (k == 1000) set_upd(0, 0, 0, 0, 0, 0);
            if (k < 1023) tick();
        end
    endtask

    initial begin
        // Directed single-update vectors: inputs and hand-computed writes.
        vt[0] = '{1, 10'h252, 4'd5,  1, 2'd1, 1, 1, 32'h0000_0C00, 32'hAAAA_AAAA};
        vt[1] = '{1, 10'h111, 4'd2,  1, 2'd3, 1, 0, 32'h0,         32'h0};
        vt[2] = '{1, 10'h222, 4'd9,  0, 2'd0, 0, 0, 32'h0,         32'h0};
        vt[3] = '{1, 10'h001, 4'd0,  0, 2'd2, 0, 1, 32'h0000_0003, 32'h5555_5555};
        vt[4] = '{1, 10'h3FF, 4'd15, 1, 2'd0, 1, 1, 32'hC000_0000, 32'h5555_5555};
        vt[5] = '{1, 10'h100, 4'd8,  0, 2'd3, 0, 1, 32'h0003_0000, 32'hAAAA_AAAA};
        vt[6] = '{1, 10'h0AB, 4'd3,  1, 2'd2, 1, 1, 32'h0000_00C0, 32'hFFFF_FFFF};
        vt[7] = '{0, 10'h0AB, 4'd3,  1, 2'd2, 1, 0, 32'h0,         32'h0};
        vt[8] = '{1, 10'h010, 4'd1,  1, 2'd1, 0, 1, 32'h0000_000C, 32'h0000_0000};

        // Reset
        bif.cp0_ifu_bht_en = 1'b1;
        bif.ifctrl_bht_inv = 1'b0;
        bif.bht_rd_busy    = 1'b0;
        set_upd(0, 0, 0, 0, 0, 0);
        #12;
        chk_all_zero("reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_idle("post_reset_idle");

        // Vector table
        for (int i = 0; i < 9; i++) begin
            set_upd(vt[i].v, vt[i].idx, vt[i].off, vt[i].sel, vt[i].cnt, vt[i].tk);
            tick();
            chk("vec_vld", bif.bht_wr_vld, vt[i].e_vld);
            chk("vec_drop", bif.bht_upd_drop, 1'b0);
            if (vt[i].e_vld)
                chk_wr("vec_wr", vt[i].idx, vt[i].sel, vt[i].e_bwen, vt[i].e_data);
        end
        set_upd(0, 0, 0, 0, 0, 0);
        tick();
        chk_idle("vec_tail_idle");

        // rd_busy stall: 5 updates, 4 fit, 5th drops; drained in order afterwards
        bif.bht_rd_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_upd(1, 10'(16 + i), 4'(i), 1, 2'd1, 1);
            if (i < 4) exp_q.push_back(10'(16 + i));
            tick();
            chk("busy_no_wr", bif.bht_wr_vld, 1'b0);
            chk("busy_drop", bif.bht_upd_drop, (i == 4) ? 1'b1 : 1'b0);
        end
        set_upd(0, 0, 0, 0, 0, 0);
        tick();
        chk_idle("busy_drop_one_cycle");
        bif.bht_rd_busy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_wr("drain_order", exp_q.pop_front(), 1'b1, 32'h3 << (2 * k), 32'hAAAA_AAAA);
        end
        tick();
        chk_idle("drain_done");

        // Full queue with a pop in the same cycle accepts the push
        bif.bht_rd_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_upd(1, 10'(32 + i), 4'd0, 0, 2'd2, 0);
            exp_q.push_back(10'(32 + i));
            tick();
        end
        bif.bht_rd_busy = 1'b0;
        set_upd(1, 10'h024, 4'd0, 0, 2'd2, 0);
        exp_q.push_back(10'h024);
        tick();
        set_upd(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            chk_wr("full_pop_push", exp_q.pop_front(), 1'b0, 32'h3, 32'h5555_5555);
            tick();
        end
        chk_idle("full_pop_push_done");

        // Invalidate with 2 queued entries and updates offered during the walk
        bif.bht_rd_busy = 1'b1;
        set_upd(1, 10'h030, 4'd1, 1, 2'd1, 1);
        tick();
        set_upd(1, 10'h031, 4'd2, 1, 2'd1, 1);
        tick();
        set_upd(0, 0, 0, 0, 0, 0);
        bif.ifctrl_bht_inv = 1'b1;
        tick();
        bif.ifctrl_bht_inv = 1'b0;
        set_upd(1, 10'h155, 4'd2, 1, 2'd1, 1);
        run_walk("inv_walk");
        tick();
        bif.bht_rd_busy = 1'b0;
        chk("inv_done_pulse", {bif.bht_ifctrl_inv_on, bif.bht_ifctrl_inv_done, bif.bht_wr_vld}, 3'b010);
        tick();
        chk("inv_done_clear", {bif.bht_ifctrl_inv_on, bif.bht_ifctrl_inv_done, bif.bht_wr_vld}, 3'b000);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_idle("inv_queue_cleared");
        end

        // cp0 disable clears queued entries and ignores updates
        bif.bht_rd_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_upd(1, 10'(64 + i), 4'd4, 1, 2'd0, 1);
            tick();
        end
        set_upd(0, 0, 0, 0, 0, 0);
        bif.cp0_ifu_bht_en = 1'b0;
        bif.bht_rd_busy = 1'b0;
        tick();
        chk_idle("dis_no_wr");
        set_upd(1, 10'h043, 4'd4, 1, 2'd0, 1);
        tick();
        chk_idle("dis_upd_ignored");
        set_upd(0, 0, 0, 0, 0, 0);
        tick();
        chk_idle("dis_still_idle");
        bif.cp0_ifu_bht_en = 1'b1;
        tick();
        chk_idle("reen_queue_empty");
        set_upd(1, 10'h044, 4'd7, 0, 2'd2, 1);
        tick();
        chk_wr("reen_one_wr", 10'h044, 1'b0, 32'h0000_C000, 32'hFFFF_FFFF);
        set_upd(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_idle("reen_exactly_one");
        end

        // Reset in the middle of a walk, then a fresh walk held high throughout
        bif.ifctrl_bht_inv = 1'b1;
        tick();
        bif.ifctrl_bht_inv = 1'b0;
        for (int k = 1; k <= 300; k++) tick();
        chk("walk_at_300", {bif.bht_ifctrl_inv_on, bif.bht_wr_vld, bif.bht_wr_idx}, {2'b11, 10'd300});
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_walk_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_all_zero("after_reset_quiet");
        end
        bif.ifctrl_bht_inv = 1'b1;
        tick();
        run_walk("restart_walk");
        tick();
        chk("restart_done", {bif.bht_ifctrl_inv_on, bif.bht_ifctrl_inv_done, bif.bht_wr_vld}, 3'b010);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("held_no_retrigger", {bif.bht_ifctrl_inv_on, bif.bht_ifctrl_inv_done, bif.bht_wr_vld}, 3'b000);
        end
        bif.ifctrl_bht_inv = 1'b0;
        tick();
        bif.ifctrl_bht_inv = 1'b1;
        tick();
        chk("rearm_after_low", {bif.bht_ifctrl_inv_on, bif.bht_wr_vld, bif.bht_wr_idx}, {2'b11, 10'd0});
        bif.ifctrl_bht_inv = 1'b0;

        // Report
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ct_ifu_bht_wr_ctrl.md
Name: ct_ifu_bht_wr_ctrl

Overview:
- Write-side controller for the IFU branch history table arrays; the counterpart of the BHT predict/read path.
- Accepts resolved conditional-branch updates from the IU and buffers them in a small queue.
- Saturates each 2-bit counter and issues bit-masked array writes in cycles where the read path does not own the array.
- Runs the full-array invalidate sequence on request from ifctrl, reporting inv_on and inv_done.

Parameters:
- IDX_WIDTH, 10, BHT array index width (1024 entries).
- QDEPTH, 4, update queue depth (power of 2, at least 2).
- INV_VAL, 2'b01, counter value written by invalidate (weakly not-taken).

Ports:
- forever_cpuclk  in  1  clock
- cpurst_b  in  1  reset, asynchronous active-low
- cp0_ifu_bht_en  in  1  BHT enable; 0 drops incoming updates and clears the queue
- ifctrl_bht_inv  in  1  invalidate request, level, sampled in IDLE only
- bht_rd_busy  in  1  read path owns the array this cycle; write must hold
- iu_bht_upd_vld  in  1  update request
- iu_bht_upd_idx  in  IDX_WIDTH  entry index
- iu_bht_upd_offset  in  4  counter slot within entry (0..15)
- iu_bht_upd_sel  in  1  1 = taken array, 0 = ntaken array
- iu_bht_upd_cnt  in  2  counter value read at prediction
- iu_bht_upd_taken  in  1  resolved direction
- bht_wr_vld  out  1  array write strobe
- bht_wr_idx  out  IDX_WIDTH  write index
- bht_wr_sel_taken  out  1  write taken array
- bht_wr_sel_ntake  out  1  write ntaken array
- bht_wr_bwen  out  32  bit write enable, 2 bits per slot
- bht_wr_data  out  32  write data, new counter replicated 16 times
- bht_upd_drop  out  1  one-cycle pulse: update discarded because the queue was full
- bht_ifctrl_inv_on  out  1  invalidate in progress
- bht_ifctrl_inv_done  out  1  one-cycle pulse on completion

Behaviour:
- Reset: all outputs 0, queue empty, FSM IDLE, walk counter 0.
- All outputs are registered.
- Push: iu_bht_upd_vld & cp0_ifu_bht_en & FSM==IDLE.
  - Full queue with no pop this cycle: update dropped, bht_upd_drop=1 next cycle.
  - Full queue with a pop this cycle: push accepted.
- Counter computation at push:
  - taken: new = (cnt==3) ? 3 : cnt+1
  - not taken: new = (cnt==0) ? 0 : cnt-1
  - new==cnt: entry is not enqueued (saturated, no write needed) and drop is not signalled.
- Pop: queue non-empty & !bht_rd_busy & FSM==IDLE. Next cycle the write is presented:
  - bht_wr_vld=1, idx as queued
  - sel_taken = sel, sel_ntake = !sel
  - bwen = 2'b11 << (2*offset)
  - data = {16{new}}
- Latency: a push into an empty queue in cycle N (rd_busy low) gives bht_wr_vld in cycle N+1. Each cycle of rd_busy adds one cycle. At most one write per cycle.
- Ordering: FIFO. Two updates to the same idx/slot are written in order, without merging.
- cp0_ifu_bht_en falling: queue cleared the same cycle; a write already registered still completes.
- FSM states:
  - IDLE: ifctrl_bht_inv -> INV. The queue is cleared and the walk counter set to 0.
  - INV: inv_on=1. Each cycle: wr_vld=1, idx=walk, both sel=1, bwen=all ones, data={16{INV_VAL}}. bht_rd_busy is ignored, because ifctrl blocks reads while inv_on. Walk increments; at walk==2^IDX_WIDTH-1 -> DONE.
  - DONE: inv_done=1 for one cycle, inv_on=0 -> IDLE.
  - Updates arriving in INV/DONE are dropped silently (no drop pulse).
- Total invalidate = 1024 write cycles + 1 done cycle.
- ifctrl_bht_inv held high through DONE does not retrigger. A new request is recognised only after it is seen low in IDLE.
- Reset mid-invalidate: returns to IDLE, inv_on=0, no inv_done pulse.

Decomposition:
- Shared package ct_ifu_bht_pkg holds:
  - FSM state encoding (IDLE/INV/DONE)
  - counter constants (SAT_MAX=3, SAT_MIN=0, INV_VAL)
  - BHT geometry: index width, 16 slots per entry, 2 bits per slot
  - queue entry typedef {idx, offset, sel, new}
- One sub-module: ct_ifu_bht_upd_fifo, a parameterised QDEPTH FIFO with push/pop/clear and full/empty flags.

Test Plan:
- Update idx=0x252, offset=5, sel=1, cnt=1, taken=1, rd_busy=0 -> next cycle wr_vld=1, idx=0x252, sel_taken=1, sel_ntake=0, bwen=0x00000C00, data=0xAAAAAAAA.
- cnt=3 taken, then cnt=0 not-taken -> no write, no drop pulse; cnt=2 not-taken on offset 0 -> bwen=0x3, data=0x55555555.
- rd_busy held high, 5 back-to-back updates -> 4 queued, 5th gives drop pulse; rd_busy low -> 4 writes on consecutive cycles in push order.
- ifctrl_bht_inv pulse with 2 queued entries -> queue cleared, inv_on for 1024 cycles with idx 0..1023 sequential, bwen=0xFFFFFFFF, data=0x55555555, then a single inv_done pulse; updates issued during INV never written.
- cp0_ifu_bht_en=0 with 3 queued entries -> no further writes; updates while disabled ignored; re-enable then 1 update -> exactly 1 write.
- cpurst_b low at walk=300 -> all outputs 0, no inv_done; after release, a new inv request restarts the walk from idx 0.
